// File: rtl/instr_fetch_unit_if.sv
//------------------------------------------------------------------------------
// instr_fetch_unit_if
// Fetch-unit bus: launch handshake, decoder feedback and the PC/status outputs.
// Optional macro: FETCH_CYCLE_CNT_EN (adds cycle_cnt).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int PC_W  = 10
`ifdef FETCH_CYCLE_CNT_EN
   ,parameter int CNT_W = 16
`endif
);
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            branch;
    logic            zero;
    logic [PC_W-1:0] target;
    logic            halt;
    logic [PC_W-1:0] prog_ctr;
    logic            fetch_vld;
    logic            done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;
`endif

    // Harness / decoder side
    modport master (
        output start, start_addr, branch, zero, target, halt,
        input  prog_ctr, fetch_vld, done
`ifdef FETCH_CYCLE_CNT_EN
       ,input  cycle_cnt
`endif
    );

    // Fetch unit side
    modport slave (
        input  start, start_addr, branch, zero, target, halt,
        output prog_ctr, fetch_vld, done
`ifdef FETCH_CYCLE_CNT_EN
       ,output cycle_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// instr_fetch_unit
// Program counter / fetch sequencer with IDLE/RUN/DONE launch handshake.
// Optional macro: FETCH_CYCLE_CNT_EN (saturating executed-instruction counter).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1024
`ifdef FETCH_CYCLE_CNT_EN
   ,parameter int CNT_W    = 16
`endif
) (
    input  wire logic         clk,
    input  wire logic         reset,
    instr_fetch_unit_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // One extra bit so the limit 2**PC_W and PC+1 at the top never wrap
    localparam logic [PC_W:0] c_PROG_LEN = (PC_W+1)'(PROG_LEN);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic            r_fetch_vld;
    logic            r_done;

    logic            w_start_ok;
    logic [PC_W:0]   w_pc_inc;
    logic [PC_W:0]   w_run_pc;
    logic            w_runaway;

    assign w_start_ok = bus.start && ({1'b0, bus.start_addr} < c_PROG_LEN);
    assign w_pc_inc   = {1'b0, r_pc} + (PC_W+1)'(1);
    assign w_run_pc   = (bus.branch && bus.zero) ? {1'b0, bus.target} : w_pc_inc;
    assign w_runaway  = (w_run_pc >= c_PROG_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= '0;
            r_fetch_vld <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_pc_next;
            r_fetch_vld <= (w_next_state == c_ST_RUN);
            r_done      <= (w_next_state == c_ST_DONE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (w_start_ok)
                    w_next_state = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (bus.halt || w_runaway)
                    w_next_state = c_ST_DONE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

`ifdef FETCH_CYCLE_CNT_EN
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] r_cnt;
`endif

    always_comb begin
        w_pc_next = r_pc;
`ifdef FETCH_CYCLE_CNT_EN
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (w_start_ok) begin
                    w_pc_next = bus.start_addr;
`ifdef FETCH_CYCLE_CNT_EN
                    w_cnt_clr = 1'b1;
`endif
                end
            end
            c_ST_RUN: begin
                // Halt or a runaway next PC freezes the PC on the last instruction
                if (!bus.halt && !w_runaway)
                    w_pc_next = w_run_pc[PC_W-1:0];
`ifdef FETCH_CYCLE_CNT_EN
                w_cnt_inc = 1'b1;
`endif
            end
            default: w_pc_next = r_pc;
        endcase
    end

`ifdef FETCH_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_cnt_clr)
            r_cnt <= '0;
        else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign bus.cycle_cnt = r_cnt;
`endif

    assign bus.prog_ctr  = r_pc;
    assign bus.fetch_vld = r_fetch_vld;
    assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed scoreboard bench for instr_fetch_unit (PROG_LEN=16 to reach the guard).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

    localparam int PC_W     = 10;
    localparam int PROG_LEN = 16;
    localparam int CNT_W    = 16;

    typedef struct {
        string           tag;
        logic [PC_W-1:0] pc;
        logic            vld;
        logic            done;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   n_tests;
    int   n_fail;

`ifdef FETCH_CYCLE_CNT_EN
    instr_fetch_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
    instr_fetch_unit #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    instr_fetch_unit_if #(.PC_W(PC_W)) bus ();
    instr_fetch_unit #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic st, input int addr, input logic br, input logic z,
                         input int tgt, input logic h);
        bus.start      = st;
        bus.start_addr = PC_W'(addr);
        bus.branch     = br;
        bus.zero       = z;
        bus.target     = PC_W'(tgt);
        bus.halt       = h;
    endtask

    task automatic expect_out(input string tag, input int pc, input logic vld,
                              input logic dn, input int cnt);
        exp_t e;
        e.tag  = tag;
        e.pc   = PC_W'(pc);
        e.vld  = vld;
        e.done = dn;
        e.cnt  = CNT_W'(cnt);
        sb.push_back(e);
    endtask

    task automatic check_one();
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        assert (bus.prog_ctr === e.pc) else begin
            n_fail++;
            $error("FAIL %s prog_ctr: got %0d expected %0d", e.tag, bus.prog_ctr, e.pc);
        end
        n_tests++;
        assert (bus.fetch_vld === e.vld) else begin
            n_fail++;
            $error("FAIL %s fetch_vld: got %0b expected %0b", e.tag, bus.fetch_vld, e.vld);
        end
        n_tests++;
        assert (bus.done === e.done) else begin
            n_fail++;
            $error("FAIL %s done: got %0b expected %0b", e.tag, bus.done, e.done);
        end
`ifdef FETCH_CYCLE_CNT_EN
        n_tests++;
        assert (bus.cycle_cnt === e.cnt) else begin
            n_fail++;
            $error("FAIL %s cycle_cnt: got %0d expected %0d", e.tag, bus.cycle_cnt, e.cnt);
        end
`endif
    endtask

    // Inputs already driven; expected state is what the DUT shows after the next edge
    task automatic step(input string tag, input int pc, input logic vld,
                        input logic dn, input int cnt);
        expect_out(tag, pc, vld, dn, cnt);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0);
        check_one();
        reset = 1'b0;

        // IDLE ignores decoder feedback
        drive(0, 0, 1, 1, 9, 1);
        step("idle_ignore", 0, 0, 0, 0);

        // T2 straight-line from 3, Start held in RUN must be ignored
        drive(1, 3, 0, 0, 0, 0);
        step("t2_start", 3, 1, 0, 0);
        drive(1, 9, 0, 0, 0, 0);
        step("t2_pc4", 4, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        step("t2_pc5", 5, 1, 0, 2);
        step("t2_pc6", 6, 1, 0, 3);
        step("t2_pc7", 7, 1, 0, 4);
        drive(0, 0, 0, 0, 0, 1);
        step("t2_halt", 7, 0, 1, 5);
        drive(0, 0, 0, 0, 0, 0);
        step("t2_hold", 7, 0, 1, 5);

        // Out-of-range launch refused in DONE
        drive(1, 16, 0, 0, 0, 0);
        step("refuse_done", 7, 0, 1, 5);

        // T3 taken / not-taken branches
        drive(1, 10, 0, 0, 0, 0);
        step("t3_start", 10, 1, 0, 0);
        drive(0, 0, 1, 1, 2, 0);
        step("t3_taken", 2, 1, 0, 1);
        drive(0, 0, 1, 1, 10, 0);
        step("t3_back", 10, 1, 0, 2);
        drive(0, 0, 1, 0, 2, 0);
        step("t3_nottaken", 11, 1, 0, 3);

        // T4 Halt beats Branch
        drive(0, 0, 1, 1, 8, 0);
        step("t4_to8", 8, 1, 0, 4);
        drive(0, 0, 1, 1, 2, 1);
        step("t4_halt_br", 8, 0, 1, 5);

        // T5 runaway guard by increment and by branch target
        drive(1, 14, 0, 0, 0, 0);
        step("t5_start", 14, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("t5_pc15", 15, 1, 0, 1);
        step("t5_inc_run", 15, 0, 1, 2);
        drive(1, 12, 0, 0, 0, 0);
        step("t5_start12", 12, 1, 0, 0);
        drive(0, 0, 1, 1, 15, 0);
        step("t5_tgt15", 15, 1, 0, 1);
        drive(0, 0, 1, 1, 20, 0);
        step("t5_tgt_run", 15, 0, 1, 2);

        // T6 relaunch at 0, then T1 async reset at PC=5
        drive(1, 0, 0, 0, 0, 0);
        step("t6_start0", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step("t1_run", i, 1, 0, i);
        #3;
        reset = 1'b1;
        #1;
        expect_out("t1_async", 0, 0, 0, 0);
        check_one();
        @(negedge clk);
        reset = 1'b0;
        drive(1, 16, 0, 0, 0, 0);
        step("refuse_idle", 0, 0, 0, 0);
        drive(1, 15, 0, 0, 0, 0);
        step("start_last", 15, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
